// File: rtl/fixed_power.sv
// ---------------------------------------------------------------------------
// fixed_power
//
// Integer-exponent power unit for unsigned Q10.10 numbers. It computes
// base**exp for exp = 0..7 by repeated multiplication through one shared
// 20x20 multiplier, performing one multiply per clock. If any partial
// product no longer fits in Q10.10, the unit stops early and returns
// SAT_VAL. Its intended use is to check the iterative root extractor: the
// root is raised back to the original power and compared with the radicand.
//
// Build option:
//   FIXED_POWER_ROUND_EN  when defined, every multiply step rounds half-up
//                         before dropping the fractional bits. When it is
//                         undefined, each step truncates. Latency and the
//                         handshake are the same in both builds.
//
// Ports:
//   clk        system clock; all logic updates on the rising edge
//   rst        synchronous, active-high reset; aborts any request in flight
//   in_valid   single-cycle request strobe; ignored while busy is high
//   in_data_1  base, unsigned Q10.10
//   in_data_2  exponent, unsigned integer 0..7
//   busy       high while a request is in flight
//   out_valid  one-cycle result strobe
//   out_data   result, unsigned Q10.10; forced to 0 when out_valid is low
// ---------------------------------------------------------------------------
module fixed_power #(
   parameter int unsigned FRAC_BITS = 10,
   parameter logic [19:0] ONE       = 20'h00400,
   parameter logic [19:0] SAT_VAL   = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [19:0] in_data_1,
   input  logic [2:0]  in_data_2,
   output logic        busy,
   output logic        out_valid,
   output logic [19:0] out_data
);

   // Rounding adds half an LSB of the result before the fractional bits
   // are dropped. The truncating build adds nothing.
`ifdef FIXED_POWER_ROUND_EN
   localparam logic [40:0] RND = 41'd1 << (FRAC_BITS - 1);
`else
   localparam logic [40:0] RND = 41'd0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      OUT
   } state_t;

   state_t      state_q, state_d;
   logic [19:0] base_q, base_d;
   logic [2:0]  exp_q, exp_d;
   logic [19:0] acc_q, acc_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        outValid_q, outValid_d;
   logic [19:0] outData_q, outData_d;

   logic [39:0] prod;
   logic [40:0] prodRnd;
   logic [40:0] scaled;
   logic        ovf;
   logic [19:0] stepVal;
   logic        lastStep;

   // One multiply step. The sum is one bit wider than the product so that
   // a rounding carry out of the top bit is still seen as an overflow.
   // Any bit at or above the integer field of the result means the value
   // cannot be represented, so the request saturates.
   assign prod     = 40'(acc_q) * 40'(base_q);
   assign prodRnd  = {1'b0, prod} + RND;
   assign scaled   = prodRnd >> FRAC_BITS;
   assign ovf      = |scaled[40:20];
   assign stepVal  = scaled[19:0];
   assign lastStep = ((cnt_q + 3'd1) == exp_q);

   // State register. Reset returns to IDLE on the same edge, even in the
   // middle of a request, so an aborted request never reaches OUT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. An exponent of zero skips MUL because the answer is
   // the initial accumulator value ONE. An overflowing multiply leaves MUL
   // at once, because a saturated value can never come back into range.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = (in_data_2 == 3'd0) ? OUT : MUL;
            end
         end
         MUL: begin
            if (ovf || lastStep) begin
               state_d = OUT;
            end
         end
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output and datapath next-state logic. busy is derived from the state,
   // so it falls in the same cycle that out_valid rises. That cycle is back
   // in IDLE, which lets a new request be accepted in the out_valid cycle.
   // Requests that arrive while busy never reach the latches below.
   always_comb begin
      base_d     = base_q;
      exp_d      = exp_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      outValid_d = 1'b0;
      outData_d  = 20'd0;
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               base_d = in_data_1;
               exp_d  = in_data_2;
               acc_d  = ONE;
               cnt_d  = 3'd0;
            end
         end
         MUL: begin
            if (ovf) begin
               acc_d = SAT_VAL;
            end else begin
               acc_d = stepVal;
               cnt_d = cnt_q + 3'd1;
            end
         end
         OUT: begin
            outValid_d = 1'b1;
            outData_d  = acc_q;
         end
         default: begin
            outValid_d = 1'b0;
         end
      endcase
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q     <= 20'd0;
         exp_q      <= 3'd0;
         acc_q      <= 20'd0;
         cnt_q      <= 3'd0;
         outValid_q <= 1'b0;
         outData_q  <= 20'd0;
      end else begin
         base_q     <= base_d;
         exp_q      <= exp_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
      end
   end

   assign out_valid = outValid_q;
   assign out_data  = outData_q;

endmodule
